// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared state encoding, default widths, halt word and memory read/write codes
package instruction_fetch_unit_pkg;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 19;
  localparam logic [DEF_DATA_WIDTH-1:0] DEF_HALT_WORD = 19'h7FFFF;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ = 1'b0;
  typedef enum logic [1:0] {LOAD = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;
endpackage

// File: rtl/instruction_fetch_unit_fetch_next_pc.sv
// fetch_next_pc: next-PC mux (jump > branch > pc+1); ports pc, branch_taken, branch_offset, jump, jump_target -> next_pc, pc_plus1
module fetch_next_pc
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_offset,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic [ADDR_WIDTH-1:0] pc_plus1
);
  assign pc_plus1 = pc + ADDR_WIDTH'(1);
  assign next_pc = jump ? jump_target : branch_taken ? pc_plus1 + branch_offset : pc_plus1;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: LOAD streams load_* words into imem, RUN fetches at pc to decode (instruction/pc/pc_plus1/instr_valid), HALT on halt word (halted); controls stall/branch/jump
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] START_PC = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_offset,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [DATA_WIDTH-1:0] imem_data,
  output logic                  imem_read_write,
  input  logic [DATA_WIDTH-1:0] imem_instruction,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus1,
  output logic                  instr_valid,
  output logic                  halted
);
  state_t state;
  logic [ADDR_WIDTH-1:0] load_addr, next_pc;
  fetch_next_pc #(.ADDR_WIDTH(ADDR_WIDTH)) u_next_pc (
    .pc(pc),
    .branch_taken(branch_taken),
    .branch_offset(branch_offset),
    .jump(jump),
    .jump_target(jump_target),
    .next_pc(next_pc),
    .pc_plus1(pc_plus1)
  );
  assign load_ready = state == LOAD;
  assign imem_address = state == LOAD ? load_addr : pc;
  assign imem_data = state == LOAD ? load_data : '0;
  assign imem_read_write = (state == LOAD && load_valid) ? RW_WRITE : RW_READ;
  assign instruction = state == RUN ? imem_instruction : '0;
  assign instr_valid = state == RUN && !stall;
  assign halted = state == HALT;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      load_addr <= '0;
      pc <= START_PC;
    end else begin
      case (state)
        LOAD: if (load_valid) begin
          load_addr <= load_addr + ADDR_WIDTH'(1);
          if (load_last || &load_addr) begin
            state <= RUN;
            load_addr <= '0;
            pc <= START_PC;
          end
        end
        RUN: if (!stall) begin
          if (imem_instruction == HALT_WORD) state <= HALT;
          else pc <= next_pc;
        end
        HALT: state <= HALT;
        default: begin
          state <= LOAD;
          load_addr <= '0;
          pc <= START_PC;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed bench with a combinational-read instruction memory model
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic rst_n, load_valid, load_last, load_ready, stall, branch_taken, jump;
  logic [18:0] load_data, imem_data, imem_instruction, instruction;
  logic [11:0] branch_offset, jump_target, imem_address, pc, pc_plus1;
  logic imem_read_write, instr_valid, halted;
  logic [18:0] mem [0:4095] = '{default: 19'h0};
  int n = 0;
  int fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (imem_read_write) mem[imem_address] <= imem_data;
  assign imem_instruction = mem[imem_address];
  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
    .jump_target(jump_target), .imem_address(imem_address), .imem_data(imem_data),
    .imem_read_write(imem_read_write), .imem_instruction(imem_instruction),
    .instruction(instruction), .pc(pc), .pc_plus1(pc_plus1),
    .instr_valid(instr_valid), .halted(halted)
  );
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic load_word(input logic [18:0] d, input logic last);
    load_valid = 1'b1;
    load_data = d;
    load_last = last;
    cyc();
    load_valid = 1'b0;
    load_last = 1'b0;
    #1;
  endtask
  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_offset = '0; jump = 1'b0; jump_target = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_rw", imem_read_write, 0);
    chk("rst_addr", imem_address, 0);
    chk("rst_pc", pc, 0);
    load_valid = 1'b1; load_data = 19'h00005; #1;
    chk("ld0_rw", imem_read_write, 1);
    chk("ld0_addr", imem_address, 0);
    chk("ld0_data", imem_data, 19'h00005);
    cyc();
    load_data = 19'h0000A; #1;
    chk("ld1_addr", imem_address, 1);
    cyc();
    load_data = 19'h00005; load_last = 1'b1; #1;
    chk("ld2_addr", imem_address, 2);
    chk("ld2_ready", load_ready, 1);
    cyc();
    load_valid = 1'b0; load_last = 1'b0; #1;
    chk("run_valid", instr_valid, 1);
    chk("run_pc", pc, 0);
    chk("run_instr", instruction, 19'h00005);
    chk("run_ready", load_ready, 0);
    chk("run_rw", imem_read_write, 0);
    chk("run_pc_plus1", pc_plus1, 1);
    chk("mem1", mem[1], 19'h0000A);
    chk("mem2", mem[2], 19'h00005);
    cyc();
    chk("seq_pc1", pc, 1);
    chk("seq_instr1", instruction, 19'h0000A);
    repeat (9) cyc();
    chk("br_pc10", pc, 10);
    branch_taken = 1'b1; branch_offset = 12'hFFD;
    cyc();
    chk("br_back", pc, 8);
    jump = 1'b1; jump_target = 12'd100;
    cyc();
    chk("jump_over_branch", pc, 100);
    branch_taken = 1'b0; jump_target = 12'd5;
    cyc();
    chk("jump_to5", pc, 5);
    stall = 1'b1; jump_target = 12'd200;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_valid", instr_valid, 0);
      chk("stall_pc", pc, 5);
      cyc();
    end
    stall = 1'b0; jump = 1'b0; #1;
    chk("unstall_pc", pc, 5);
    chk("unstall_valid", instr_valid, 1);
    cyc();
    chk("unstall_next", pc, 6);
    cyc();
    chk("pre_rst_pc", pc, 7);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; #1;
    chk("mid_rst_ready", load_ready, 1);
    chk("mid_rst_addr", imem_address, 0);
    chk("mid_rst_valid", instr_valid, 0);
    load_word(19'h00009, 1'b1);
    chk("reload_pc", pc, 0);
    chk("reload_instr", instruction, 19'h00009);
    cyc();
    chk("persist_1", instruction, 19'h0000A);
    cyc();
    chk("persist_2", instruction, 19'h00005);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    load_word(19'h00011, 1'b0);
    load_word(19'h00022, 1'b0);
    load_word(19'h00033, 1'b0);
    load_word(19'h7FFFF, 1'b1);
    chk("h_pc0", pc, 0);
    chk("h_instr0", instruction, 19'h00011);
    cyc(); cyc(); cyc();
    jump = 1'b1; jump_target = 12'd50; #1;
    chk("h_pc3", pc, 3);
    chk("h_valid_at_halt", instr_valid, 1);
    chk("h_instr_halt", instruction, 19'h7FFFF);
    chk("h_not_yet", halted, 0);
    load_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("h_halted", halted, 1);
      chk("h_valid", instr_valid, 0);
      chk("h_pc", pc, 3);
    end
    chk("h_rw", imem_read_write, 0);
    load_valid = 1'b0; jump = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      load_valid = 1'b1; load_data = 19'(i); load_last = 1'b0;
      if (i == 4095) begin
        #1;
        chk("full_last_addr", imem_address, 4095);
      end
      cyc();
    end
    load_valid = 1'b0; #1;
    chk("full_run", load_ready, 0);
    chk("full_pc0", pc, 0);
    chk("full_mem4095", mem[4095], 19'h00FFF);
    repeat (4095) cyc();
    chk("wrap_pc", pc, 4095);
    chk("wrap_instr", instruction, 19'h00FFF);
    chk("wrap_pc_plus1", pc_plus1, 0);
    cyc();
    chk("wrap_to0", pc, 0);
    chk("wrap_instr0", instruction, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
